// File: rtl/bytecode_ctrl.sv
// rtl/bytecode_ctrl.sv - JVM integer bytecode control unit with eval-stack depth tracking
//
// Decodes one bytecode per op_valid/op_ready handshake and sequences eval-stack
// pops/pushes and LVA reads/writes over req/ack interfaces, then reports the PC
// delta for the fetch stage.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   op_valid/op_ready           instruction handshake (ready only in IDLE)
//   op_code, arg1, arg2         bytecode and operand bytes, latched at accept
//   stk_push/stk_pop            stack requests, held until stk_ack
//   stk_wdata/stk_rdata         push data / pop data (valid with stk_ack)
//   lva_read/lva_write          LVA requests, held until lva_ack
//   lva_index/lva_wdata/lva_rdata  LVA slot, write data, read data
//   op_done                     one-cycle completion pulse
//   offset, branch_taken        signed PC delta and branch flag, valid with op_done
//   illegal, stk_err            undecoded opcode / stack over-underflow, with op_done
//   depth                       current stack occupancy
module bytecode_ctrl #(
    parameter int DATA_W      = 32,
    parameter int LVA_IDX_W   = 8,
    parameter int STACK_DEPTH = 64,
    parameter int OFFSET_W    = 16,
    localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [7:0]           op_code,
    input  logic [7:0]           arg1,
    input  logic [7:0]           arg2,
    output logic                 stk_push,
    output logic                 stk_pop,
    output logic [DATA_W-1:0]    stk_wdata,
    input  logic [DATA_W-1:0]    stk_rdata,
    input  logic                 stk_ack,
    output logic                 lva_read,
    output logic                 lva_write,
    output logic [LVA_IDX_W-1:0] lva_index,
    output logic [DATA_W-1:0]    lva_wdata,
    input  logic [DATA_W-1:0]    lva_rdata,
    input  logic                 lva_ack,
    output logic                 op_done,
    output logic [OFFSET_W-1:0]  offset,
    output logic                 branch_taken,
    output logic                 illegal,
    output logic                 stk_err,
    output logic [DEPTH_W-1:0]   depth
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_POP_B  = 3'd1;
    localparam logic [2:0] S_POP_A  = 3'd2;
    localparam logic [2:0] S_LVA_RD = 3'd3;
    localparam logic [2:0] S_LVA_WR = 3'd4;
    localparam logic [2:0] S_PUSH   = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    // Instruction classes: each class has a fixed transaction sequence.
    localparam logic [3:0] C_NOP    = 4'd0;
    localparam logic [3:0] C_CONST  = 4'd1;
    localparam logic [3:0] C_ILOAD  = 4'd2;
    localparam logic [3:0] C_ISTORE = 4'd3;
    localparam logic [3:0] C_POP    = 4'd4;
    localparam logic [3:0] C_ALU    = 4'd5;
    localparam logic [3:0] C_GOTO   = 4'd6;
    localparam logic [3:0] C_IF     = 4'd7;
    localparam logic [3:0] C_ILL    = 4'd8;

    function automatic logic [3:0] classify(input logic [7:0] op);
        case (op) inside
            8'h00:                              return C_NOP;
            [8'h02:8'h08], 8'h10, 8'h11:        return C_CONST;
            8'h15, [8'h1A:8'h1D]:               return C_ILOAD;
            8'h36, [8'h3B:8'h3E]:               return C_ISTORE;
            8'h57:                              return C_POP;
            8'h60, 8'h64, 8'h7E, 8'h80, 8'h82:  return C_ALU;
            8'hA7:                              return C_GOTO;
            8'h99, 8'h9A:                       return C_IF;
            default:                            return C_ILL;
        endcase
    endfunction

    logic [2:0]           state;
    logic [3:0]           cls_q;
    logic [7:0]           op_q, arg1_q, arg2_q;
    logic [LVA_IDX_W-1:0] idx_q;
    logic [DATA_W-1:0]    a_q, b_q, lva_q;
    logic                 err_q;
    logic [DEPTH_W-1:0]   depth_q;

    // Accept-time decode and depth check on the incoming opcode.
    logic [3:0]         cls_in;
    logic [1:0]         pops_in;
    logic               push_in;
    logic [7:0]         idx8_in;
    logic [DEPTH_W:0]   d_ext, n_pop, n_push, d_after;
    logic               stk_bad_in;

    always_comb begin
        cls_in  = classify(op_code);
        pops_in = 2'd0;
        push_in = 1'b0;
        case (cls_in)
            C_ISTORE, C_POP, C_IF: pops_in = 2'd1;
            C_ALU:                 pops_in = 2'd2;
            default:               pops_in = 2'd0;
        endcase
        push_in = (cls_in == C_CONST) || (cls_in == C_ILOAD) || (cls_in == C_ALU);
        if (op_code == 8'h15 || op_code == 8'h36)
            idx8_in = arg1;
        else if (cls_in == C_ILOAD)
            idx8_in = op_code - 8'h1A;
        else
            idx8_in = op_code - 8'h3B;
        d_ext   = {1'b0, depth_q};
        n_pop   = (DEPTH_W+1)'(pops_in);
        n_push  = (DEPTH_W+1)'(push_in);
        d_after = d_ext - n_pop + n_push;
        // d_after may wrap on underflow, but the first term already flags that case.
        stk_bad_in = (n_pop > d_ext) || (d_after > (DEPTH_W+1)'(STACK_DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cls_q   <= C_NOP;
            op_q    <= '0;
            arg1_q  <= '0;
            arg2_q  <= '0;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            lva_q   <= '0;
            err_q   <= 1'b0;
            depth_q <= '0;
        end else begin
            case (state)
                S_IDLE: if (op_valid) begin
                    cls_q  <= cls_in;
                    op_q   <= op_code;
                    arg1_q <= arg1;
                    arg2_q <= arg2;
                    idx_q  <= LVA_IDX_W'(idx8_in);
                    err_q  <= stk_bad_in;
                    if (stk_bad_in)
                        state <= S_DONE;
                    else begin
                        case (cls_in)
                            C_CONST: state <= S_PUSH;
                            C_ILOAD: state <= S_LVA_RD;
                            C_ISTORE, C_POP, C_ALU, C_IF: state <= S_POP_B;
                            default: state <= S_DONE;
                        endcase
                    end
                end
                S_POP_B: if (stk_ack) begin
                    b_q     <= stk_rdata;
                    depth_q <= depth_q - DEPTH_W'(1);
                    if (cls_q == C_ALU)
                        state <= S_POP_A;
                    else if (cls_q == C_ISTORE)
                        state <= S_LVA_WR;
                    else
                        state <= S_DONE;
                end
                S_POP_A: if (stk_ack) begin
                    a_q     <= stk_rdata;
                    depth_q <= depth_q - DEPTH_W'(1);
                    state   <= S_PUSH;
                end
                S_LVA_RD: if (lva_ack) begin
                    lva_q <= lva_rdata;
                    state <= S_PUSH;
                end
                S_LVA_WR: if (lva_ack) state <= S_DONE;
                S_PUSH: if (stk_ack) begin
                    depth_q <= depth_q + DEPTH_W'(1);
                    state   <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Datapath values derived from latched instruction and operands.
    logic [7:0]          k8;
    logic [15:0]         imm16;
    logic [DATA_W-1:0]   push_val;
    logic                taken;
    logic [OFFSET_W-1:0] off_val;

    always_comb begin
        k8       = op_q - 8'd3;
        imm16    = {arg1_q, arg2_q};
        push_val = '0;
        case (cls_q)
            C_CONST: begin
                if (op_q == 8'h10)
                    push_val = DATA_W'($signed(arg1_q));
                else if (op_q == 8'h11)
                    push_val = DATA_W'($signed(imm16));
                else
                    push_val = DATA_W'($signed(k8));
            end
            C_ILOAD: push_val = lva_q;
            C_ALU: begin
                case (op_q)
                    8'h60:   push_val = a_q + b_q;
                    8'h64:   push_val = a_q - b_q;
                    8'h7E:   push_val = a_q & b_q;
                    8'h80:   push_val = a_q | b_q;
                    default: push_val = a_q ^ b_q;
                endcase
            end
            default: push_val = '0;
        endcase

        taken = 1'b0;
        if (!err_q) begin
            if (cls_q == C_GOTO)
                taken = 1'b1;
            else if (cls_q == C_IF)
                taken = (op_q == 8'h99) ? (b_q == '0) : (b_q != '0);
        end

        off_val = OFFSET_W'(1);
        if (!err_q) begin
            if (taken)
                off_val = OFFSET_W'($signed(imm16));
            else if (cls_q == C_IF || op_q == 8'h11)
                off_val = OFFSET_W'(3);
            else if (op_q == 8'h10 || op_q == 8'h15 || op_q == 8'h36)
                off_val = OFFSET_W'(2);
        end
    end

    // Outputs decode from state so reset clears them without waiting for a clock.
    assign op_ready     = (state == S_IDLE);
    assign stk_pop      = (state == S_POP_B) || (state == S_POP_A);
    assign stk_push     = (state == S_PUSH);
    assign stk_wdata    = stk_push ? push_val : '0;
    assign lva_read     = (state == S_LVA_RD);
    assign lva_write    = (state == S_LVA_WR);
    assign lva_index    = (lva_read || lva_write) ? idx_q : '0;
    assign lva_wdata    = lva_write ? b_q : '0;
    assign op_done      = (state == S_DONE);
    assign offset       = op_done ? off_val : '0;
    assign branch_taken = op_done && taken;
    assign illegal      = op_done && !err_q && (cls_q == C_ILL);
    assign stk_err      = op_done && err_q;
    assign depth        = depth_q;

endmodule

// File: tb/tb_bytecode_ctrl.sv
// tb/tb_bytecode_ctrl.sv - directed self-checking bench for bytecode_ctrl
module tb_bytecode_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        op_valid = 1'b0;
    logic [7:0]  op_code = 8'h00, arg1 = 8'h00, arg2 = 8'h00;

    // 32-bit instance
    logic        op_ready, stk_push, stk_pop, stk_ack, lva_read, lva_write, lva_ack;
    logic        op_done, branch_taken, illegal, stk_err;
    logic [31:0] stk_wdata, stk_rdata, lva_wdata, lva_rdata;
    logic [7:0]  lva_index;
    logic [15:0] offset;
    logic [6:0]  depth;

    // 8-bit instance, driven with the same instruction stream
    logic        op_ready8, stk_push8, stk_pop8, stk_ack8, lva_read8, lva_write8, lva_ack8;
    logic        op_done8, branch_taken8, illegal8, stk_err8;
    logic [7:0]  stk_wdata8, stk_rdata8, lva_wdata8, lva_rdata8, lva_index8;
    logic [15:0] offset8;
    logic [6:0]  depth8;

    bytecode_ctrl dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .arg1(arg1), .arg2(arg2),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_wdata(stk_wdata),
        .stk_rdata(stk_rdata), .stk_ack(stk_ack),
        .lva_read(lva_read), .lva_write(lva_write), .lva_index(lva_index),
        .lva_wdata(lva_wdata), .lva_rdata(lva_rdata), .lva_ack(lva_ack),
        .op_done(op_done), .offset(offset), .branch_taken(branch_taken),
        .illegal(illegal), .stk_err(stk_err), .depth(depth)
    );

    bytecode_ctrl #(.DATA_W(8)) dut8 (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready8),
        .op_code(op_code), .arg1(arg1), .arg2(arg2),
        .stk_push(stk_push8), .stk_pop(stk_pop8), .stk_wdata(stk_wdata8),
        .stk_rdata(stk_rdata8), .stk_ack(stk_ack8),
        .lva_read(lva_read8), .lva_write(lva_write8), .lva_index(lva_index8),
        .lva_wdata(lva_wdata8), .lva_rdata(lva_rdata8), .lva_ack(lva_ack8),
        .op_done(op_done8), .offset(offset8), .branch_taken(branch_taken8),
        .illegal(illegal8), .stk_err(stk_err8), .depth(depth8)
    );

    // Stack and LVA memories with programmable ack delay (32-bit instance)
    int          stk_delay = 0, lva_delay = 0, stk_wait, lva_wait, sp, sp8;
    logic [31:0] stk_mem [0:63];
    logic [31:0] lva_mem [0:255];
    logic [7:0]  stk_mem8 [0:63];
    logic [31:0] last_push;
    logic [7:0]  last_push8;

    assign stk_ack   = (stk_push || stk_pop) && (stk_wait >= stk_delay);
    assign lva_ack   = (lva_read || lva_write) && (lva_wait >= lva_delay);
    assign stk_rdata = (sp > 0) ? stk_mem[sp-1] : 32'h0;
    assign lva_rdata = lva_mem[lva_index];
    assign stk_ack8  = stk_push8 || stk_pop8;
    assign lva_ack8  = lva_read8 || lva_write8;
    assign stk_rdata8 = (sp8 > 0) ? stk_mem8[sp8-1] : 8'h0;
    assign lva_rdata8 = 8'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sp <= 0; sp8 <= 0; stk_wait <= 0; lva_wait <= 0;
            last_push <= 32'h0; last_push8 <= 8'h0;
        end else begin
            if (stk_push && stk_ack) begin
                stk_mem[sp] <= stk_wdata; sp <= sp + 1; last_push <= stk_wdata;
            end else if (stk_pop && stk_ack) sp <= sp - 1;
            stk_wait <= ((stk_push || stk_pop) && !stk_ack) ? stk_wait + 1 : 0;
            if (lva_write && lva_ack) lva_mem[lva_index] <= lva_wdata;
            lva_wait <= ((lva_read || lva_write) && !lva_ack) ? lva_wait + 1 : 0;
            if (stk_push8) begin
                stk_mem8[sp8] <= stk_wdata8; sp8 <= sp8 + 1; last_push8 <= stk_wdata8;
            end else if (stk_pop8) sp8 <= sp8 - 1;
        end
    end

    int passed = 0, total = 0;
    int r_cyc, pop_cyc, wr_cyc;
    logic [15:0] r_off, r_off8;
    logic        r_taken, r_ill, r_err, r_ill8;
    logic [6:0]  r_depth, r_depth8;
    logic [7:0]  wr_idx;
    logic [31:0] wr_data;

    // Issue one instruction and observe both instances until the 32-bit one completes.
    task automatic run(input logic [7:0] op, input logic [7:0] a1, input logic [7:0] a2);
        int n;
        bit got;
        got = 0; pop_cyc = 0; wr_cyc = 0; r_cyc = 0;
        @(negedge clk);
        op_code = op; arg1 = a1; arg2 = a2; op_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0; op_code = 8'h60; arg1 = ~a1; arg2 = ~a2;
        n = 1;
        while (!got && n <= 40) begin
            if (n > 1) @(negedge clk);
            if (stk_pop) pop_cyc++;
            if (lva_write) begin wr_cyc++; wr_idx = lva_index; wr_data = lva_wdata; end
            if (op_done8) begin r_off8 = offset8; r_ill8 = illegal8; r_depth8 = depth8; end
            if (op_done) begin
                got = 1; r_cyc = n; r_off = offset; r_taken = branch_taken;
                r_ill = illegal; r_err = stk_err; r_depth = depth;
            end
            n++;
        end
        if (!got) begin
            total++;
            $display("FAIL timeout op %h: op_done not seen within 40 cycles", op);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (op_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", op_ready); else passed++;
        total++; if (depth !== 7'd0) $display("FAIL rst_depth got %0d want 0", depth); else passed++;
        total++; if ({op_done, offset} !== 17'd0) $display("FAIL rst_done_off got %h want 0", {op_done, offset}); else passed++;
        total++; if ({stk_push, stk_pop, lva_read, lva_write} !== 4'b0) $display("FAIL rst_req got %b want 0000", {stk_push, stk_pop, lva_read, lva_write}); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_const_add();
        run(8'h02, 8'h00, 8'h00);
        total++; if (last_push !== 32'hFFFFFFFF) $display("FAIL iconst_m1 got %h want ffffffff", last_push); else passed++;
        total++; if (r_depth !== 7'd1 || r_off !== 16'd1) $display("FAIL iconst_m1_dep_off got %0d/%0d want 1/1", r_depth, r_off); else passed++;
        run(8'h05, 8'h00, 8'h00);
        total++; if (last_push !== 32'd2 || r_depth !== 7'd2) $display("FAIL iconst_2a got %h/%0d want 2/2", last_push, r_depth); else passed++;
        run(8'h05, 8'h00, 8'h00);
        total++; if (last_push !== 32'd2 || r_depth !== 7'd3) $display("FAIL iconst_2b got %h/%0d want 2/3", last_push, r_depth); else passed++;
        run(8'h60, 8'h00, 8'h00);
        total++; if (last_push !== 32'd4) $display("FAIL iadd1 got %h want 4", last_push); else passed++;
        total++; if (r_cyc !== 4) $display("FAIL iadd1_latency got %0d want 4", r_cyc); else passed++;
        total++; if (r_depth !== 7'd2 || r_off !== 16'd1 || r_ill !== 1'b0) $display("FAIL iadd1_dep_off_ill got %0d/%0d/%b want 2/1/0", r_depth, r_off, r_ill); else passed++;
    endtask

    task automatic test_stack_err();
        run(8'h60, 8'h00, 8'h00);
        total++; if (last_push !== 32'd3 || r_depth !== 7'd1) $display("FAIL iadd2 got %h/%0d want 3/1", last_push, r_depth); else passed++;
        run(8'h60, 8'h00, 8'h00);
        total++; if (r_err !== 1'b1) $display("FAIL underflow_err got %b want 1", r_err); else passed++;
        total++; if (pop_cyc !== 0) $display("FAIL underflow_pops got %0d want 0", pop_cyc); else passed++;
        total++; if (r_depth !== 7'd1 || r_off !== 16'd1) $display("FAIL underflow_dep_off got %0d/%0d want 1/1", r_depth, r_off); else passed++;
    endtask

    task automatic test_lva();
        run(8'h10, 8'h80, 8'h00);
        total++; if (last_push !== 32'hFFFFFF80 || r_off !== 16'd2) $display("FAIL bipush got %h/%0d want ffffff80/2", last_push, r_off); else passed++;
        lva_delay = 3;
        run(8'h36, 8'h05, 8'h00);
        total++; if (wr_cyc !== 4) $display("FAIL istore_hold got %0d want 4", wr_cyc); else passed++;
        total++; if (wr_idx !== 8'd5 || wr_data !== 32'hFFFFFF80) $display("FAIL istore_idx_data got %0d/%h want 5/ffffff80", wr_idx, wr_data); else passed++;
        total++; if (r_off !== 16'd2 || r_depth !== 7'd1) $display("FAIL istore_off_dep got %0d/%0d want 2/1", r_off, r_depth); else passed++;
        lva_delay = 0;
        run(8'h15, 8'h05, 8'h00);
        total++; if (last_push !== 32'hFFFFFF80 || r_off !== 16'd2 || r_depth !== 7'd2) $display("FAIL iload got %h/%0d/%0d want ffffff80/2/2", last_push, r_off, r_depth); else passed++;
    endtask

    task automatic test_branch();
        run(8'h03, 8'h00, 8'h00);
        run(8'h99, 8'hFF, 8'hF0);
        total++; if (r_taken !== 1'b1 || r_off !== 16'hFFF0) $display("FAIL ifeq_taken got %b/%h want 1/fff0", r_taken, r_off); else passed++;
        total++; if (r_depth !== 7'd2) $display("FAIL ifeq_depth got %0d want 2", r_depth); else passed++;
        run(8'h10, 8'h07, 8'h00);
        run(8'h99, 8'hFF, 8'hF0);
        total++; if (r_taken !== 1'b0 || r_off !== 16'd3) $display("FAIL ifeq_not_taken got %b/%0d want 0/3", r_taken, r_off); else passed++;
        run(8'hA7, 8'h00, 8'h10);
        total++; if (r_taken !== 1'b1 || r_off !== 16'h0010 || r_depth !== 7'd2) $display("FAIL goto got %b/%h/%0d want 1/0010/2", r_taken, r_off, r_depth); else passed++;
    endtask

    task automatic test_narrow();
        run(8'h08, 8'h00, 8'h00);
        run(8'h10, 8'h7F, 8'h00);
        run(8'h60, 8'h00, 8'h00);
        total++; if (last_push8 !== 8'h84) $display("FAIL narrow_iadd got %h want 84", last_push8); else passed++;
        total++; if (r_depth8 !== 7'd3) $display("FAIL narrow_depth got %0d want 3", r_depth8); else passed++;
        run(8'hFF, 8'h00, 8'h00);
        total++; if (r_ill8 !== 1'b1 || r_off8 !== 16'd1) $display("FAIL narrow_illegal got %b/%0d want 1/1", r_ill8, r_off8); else passed++;
        total++; if (r_ill !== 1'b1 || pop_cyc !== 0 || r_depth !== 7'd3) $display("FAIL illegal got %b/%0d/%0d want 1/0/3", r_ill, pop_cyc, r_depth); else passed++;
    endtask

    task automatic test_reset_midflight();
        stk_delay = 5;
        @(negedge clk);
        op_code = 8'h60; op_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        total++; if (stk_pop !== 1'b1) $display("FAIL mid_pop_pending got %b want 1", stk_pop); else passed++;
        #2 rst = 1'b1;
        #1;
        total++; if ({stk_pop, stk_push, op_done, offset} !== 19'd0) $display("FAIL mid_rst_outputs got %h want 0", {stk_pop, stk_push, op_done, offset}); else passed++;
        total++; if (depth !== 7'd0 || op_ready !== 1'b1) $display("FAIL mid_rst_depth_ready got %0d/%b want 0/1", depth, op_ready); else passed++;
        stk_delay = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (op_ready !== 1'b1 || depth !== 7'd0 || stk_pop !== 1'b0) $display("FAIL mid_after_release got %b/%0d/%b want 1/0/0", op_ready, depth, stk_pop); else passed++;
    endtask

    initial begin
        test_reset();
        test_const_add();
        test_stack_err();
        test_lva();
        test_branch();
        test_narrow();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bytecode_ctrl.md
Name: bytecode_ctrl

Overview:
Parametrised successor to the fixed-width control unit. Decodes one JVM integer bytecode per handshake and sequences pops and pushes on the evaluation stack and reads and writes on the local variable array (LVA), each through a req/ack interface. It reports the PC increment or branch offset for the fetch stage. The block sits between the bytecode fetch stage and the eval-stack/LVA memories, and adds a stack-depth tracker with over/underflow detection.

Parameters:
DATA_W, 32, datapath width of stack/LVA words
LVA_IDX_W, 8, LVA index width (arg1 zero-extended/truncated to this)
STACK_DEPTH, 64, eval-stack capacity used by depth tracker
OFFSET_W, 16, width of offset output (>=16)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
op_valid  in  1  opcode/args valid
op_ready  out  1  high only in IDLE
op_code  in  8  bytecode
arg1  in  8  first operand byte
arg2  in  8  second operand byte
stk_push  out  1  push request
stk_pop  out  1  pop request
stk_wdata  out  DATA_W  push data
stk_rdata  in  DATA_W  pop data, valid with stk_ack
stk_ack  in  1  stack transaction complete (may be same cycle as request)
lva_read  out  1  LVA read request
lva_write  out  1  LVA write request
lva_index  out  LVA_IDX_W  LVA slot
lva_wdata  out  DATA_W  LVA write data
lva_rdata  in  DATA_W  valid with lva_ack
lva_ack  in  1  LVA transaction complete
op_done  out  1  one-cycle pulse at instruction completion
offset  out  OFFSET_W  signed PC delta, valid with op_done
branch_taken  out  1  valid with op_done
illegal  out  1  pulse with op_done for undecoded opcode
stk_err  out  1  pulse with op_done on over/underflow
depth  out  $clog2(STACK_DEPTH+1)  current stack occupancy

Behaviour:
- Reset (async): state IDLE; all requests, op_done, branch_taken, illegal, stk_err = 0; offset = 0; depth = 0; data/index outputs = 0. Any in-flight transaction is abandoned immediately.
- FSM states: IDLE, POP_B, POP_A, LVA_RD, LVA_WR, PUSH, DONE.
- Accept on op_valid & op_ready (rising edge). Args are latched at accept.
- A request is held high until the cycle its ack is high; the FSM advances on that edge. Pop data and LVA read data are latched on the ack edge.
- DONE lasts one cycle (op_done=1), then IDLE.
- Decode:
  - 0x00 nop: DONE, off 1.
  - 0x02-0x08 iconst: push (op-3), sign-extended; off 1.
  - 0x10 bipush: push sext(arg1); off 2.
  - 0x11 sipush: push sext({arg1,arg2}); off 3.
  - 0x15 iload: LVA_RD idx arg1 -> PUSH; off 2.
  - 0x1A-0x1D iload_n: idx n; off 1.
  - 0x36 istore: POP_B -> LVA_WR idx arg1; off 2.
  - 0x3B-0x3E istore_n: off 1.
  - 0x57 pop: POP_B; off 1.
  - 0x60 iadd, 0x64 isub, 0x7E iand, 0x80 ior, 0x82 ixor: POP_B (b) -> POP_A (a) -> PUSH a op b; off 1.
  - 0xA7 goto: taken, off sext({arg1,arg2}).
  - 0x99 ifeq / 0x9A ifne: POP_B; taken if b==0 / b!=0; off sext({arg1,arg2}) when taken, else 3.
- Arithmetic is modulo 2^DATA_W (wraps, no flags). isub computes a-b.
- Other opcodes: DONE, illegal=1, off 1, no transactions.
- Depth check at accept: if pops needed > depth, or depth - pops + pushes > STACK_DEPTH, go straight to DONE with stk_err=1, off 1, depth unchanged, no transactions.
- depth decrements on each pop ack and increments on each push ack.
- op_valid is ignored while not IDLE; args latched at accept are immune to later input changes.

Test Plan:
- Zero-wait acks; iconst_m1, iconst_2, iconst_2, iadd -> pushes 0xFFFFFFFF, 2, 2, then 4; iadd op_done 4 cycles after accept; depth 1,2,3,2.
- Second iadd on stack {-1,4} -> push 3, depth 1. Third iadd at depth 1 -> stk_err=1, no stk_pop, depth stays 1.
- bipush 0x80, istore 5 with lva_ack delayed 3 cycles -> lva_write held 4 cycles, lva_index 5, lva_wdata 0xFFFFFF80, offsets 2 and 2; then iload_... via iload 5 -> push 0xFFFFFF80.
- ifeq arg 0xFF,0xF0 with top 0 -> branch_taken=1, offset -16; with top 7 -> branch_taken=0, offset 3.
- DATA_W=8: iconst_5, bipush 0x7F, iadd -> 0x84 (wrap). Opcode 0xFF -> illegal pulse, offset 1.
- rst asserted while stk_pop pending in iadd -> all outputs 0 immediately, depth 0, op_ready=1 after release.
